// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle core: instruction field codes,
// FSM state encoding and ALU operation selects.
package multicycle_pkg;

    // Major opcodes, instruction bits [15:13]
    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_LW    = 3'b001;
    localparam logic [2:0] OP_SW    = 3'b010;
    localparam logic [2:0] OP_BEQ   = 3'b011;
    localparam logic [2:0] OP_ADDI  = 3'b100;
    localparam logic [2:0] OP_SLTI  = 3'b101;
    localparam logic [2:0] OP_J     = 3'b110;
    localparam logic [2:0] OP_JAL   = 3'b111;

    // R-type function codes, instruction bits [3:0]
    localparam logic [3:0] FN_ADD = 4'b0000;
    localparam logic [3:0] FN_SUB = 4'b0001;
    localparam logic [3:0] FN_AND = 4'b0010;
    localparam logic [3:0] FN_OR  = 4'b0011;
    localparam logic [3:0] FN_SLT = 4'b0100;
    localparam logic [3:0] FN_JR  = 4'b1000;

    // jal always links into this register
    localparam logic [2:0] LINK_REG = 3'd7;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    // True for R-type functs that produce a register result
    function automatic logic is_alu_funct(input logic [3:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT);
    endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU for the multicycle core: add/sub/and/or/slt with a
// zero flag used by beq. slt compare signedness is fixed at elaboration.
module mc_alu
    import multicycle_pkg::*;
#(
    parameter int DW         = 16,
    parameter bit SLT_SIGNED = 1'b0
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  alu_op_t       op,
    output logic [DW-1:0] result,
    output logic          zero
);

    logic less;

    // Less-than in the configured signedness
    always_comb begin
        less = SLT_SIGNED ? ($signed(a) < $signed(b)) : (a < b);
    end

    // Operation select; everything wraps modulo 2^DW
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(DW-1){1'b0}}, less};
            default: result = '0;
        endcase
    end

    assign zero = ~|result;

endmodule

// File: rtl/multicycle_core.sv
// Five-state multicycle processor core (FETCH/DECODE/EXEC/MEM/WB) with a
// 16-bit instruction format, 8 x DW register file and separate
// request/ready instruction and data ports.
module multicycle_core
    import multicycle_pkg::*;
#(
    parameter int DW         = 16,
    parameter bit SLT_SIGNED = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [DW-1:0] imem_addr,
    input  logic [15:0]   imem_rdata,
    input  logic          imem_ready,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          dmem_ready,
    output logic [DW-1:0] pc_out,
    output logic          retire,
    output logic          illegal
);

    state_t        state;
    state_t        state_next;

    logic [15:0]   ir;
    logic [DW-1:0] pc;
    logic [DW-1:0] pc_next;
    logic [DW-1:0] a_reg;
    logic [DW-1:0] b_reg;
    logic [DW-1:0] alu_out;
    logic [DW-1:0] mdr;
    logic [DW-1:0] regs [8];

    // Instruction fields (rd/funct overlap the immediate by design)
    logic [2:0]    opcode;
    logic [2:0]    rs;
    logic [2:0]    rt;
    logic [2:0]    rd;
    logic [3:0]    funct;
    logic [12:0]   target;

    assign opcode = ir[15:13];
    assign rs     = ir[12:10];
    assign rt     = ir[9:7];
    assign rd     = ir[6:4];
    assign funct  = ir[3:0];
    assign target = ir[12:0];

    logic          funct_is_alu;
    logic          funct_is_jr;

    assign funct_is_alu = is_alu_funct(funct);
    assign funct_is_jr  = (funct == FN_JR);

    // Address arithmetic
    logic [DW-1:0] imm_sext;
    logic [DW-1:0] pc_plus2;
    logic [DW-1:0] branch_target;
    logic [DW-1:0] jump_target;

    assign imm_sext      = {{(DW-7){ir[6]}}, ir[6:0]};
    assign pc_plus2      = pc + DW'(2);
    assign branch_target = pc_plus2 + {imm_sext[DW-2:0], 1'b0};
    assign jump_target   = {pc_plus2[DW-1:14], target, 1'b0};

    // Register file read ports; R0 is hardwired to zero
    logic [DW-1:0] rf_rdata_a;
    logic [DW-1:0] rf_rdata_b;

    assign rf_rdata_a = (rs == 3'd0) ? '0 : regs[rs];
    assign rf_rdata_b = (rt == 3'd0) ? '0 : regs[rt];

    // ALU
    alu_op_t       alu_op;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_result;
    logic          alu_zero;

    // ALU operation and second operand chosen from the opcode/funct
    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = imm_sext;
        case (opcode)
            OP_RTYPE: begin
                alu_b = b_reg;
                case (funct)
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            OP_BEQ: begin
                alu_b  = b_reg;
                alu_op = ALU_SUB;
            end
            OP_SLTI: alu_op = ALU_SLT;
            default: alu_op = ALU_ADD;
        endcase
    end

    mc_alu #(
        .DW         (DW),
        .SLT_SIGNED (SLT_SIGNED)
    ) u_alu (
        .a      (a_reg),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake/status outputs; reset forces every strobe low
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        retire     = 1'b0;
        illegal    = 1'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    state_next = DECODE;
                end
            end
            DECODE: state_next = EXEC;
            EXEC: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (funct_is_alu) begin
                            state_next = WB;
                        end else begin
                            state_next = FETCH;
                            retire     = 1'b1;
                            illegal    = !funct_is_jr;
                        end
                    end
                    OP_ADDI, OP_SLTI: state_next = WB;
                    OP_LW, OP_SW:     state_next = MEM;
                    default: begin
                        state_next = FETCH;
                        retire     = 1'b1;
                    end
                endcase
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opcode == OP_SW);
                if (dmem_ready) begin
                    if (opcode == OP_LW) begin
                        state_next = WB;
                    end else begin
                        state_next = FETCH;
                        retire     = 1'b1;
                    end
                end
            end
            WB: begin
                retire     = 1'b1;
                state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
        if (rst) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            retire   = 1'b0;
            illegal  = 1'b0;
        end
    end

    // PC candidate for the end of EXEC: branch, jump, jr or fall-through
    always_comb begin
        pc_next = pc_plus2;
        case (opcode)
            OP_BEQ: begin
                if (alu_zero) begin
                    pc_next = branch_target;
                end
            end
            OP_J, OP_JAL: pc_next = jump_target;
            OP_RTYPE: begin
                if (funct_is_jr) begin
                    pc_next = a_reg;
                end
            end
            default: pc_next = pc_plus2;
        endcase
    end

    // Register write port: jal links in EXEC, everything else writes in WB
    logic          rf_we;
    logic [2:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = rd;
        rf_wdata = alu_out;
        if ((state == EXEC) && (opcode == OP_JAL)) begin
            rf_we    = 1'b1;
            rf_waddr = LINK_REG;
            rf_wdata = pc_plus2;
        end else if (state == WB) begin
            rf_we = 1'b1;
            case (opcode)
                OP_RTYPE: rf_waddr = rd;
                OP_LW: begin
                    rf_waddr = rt;
                    rf_wdata = mdr;
                end
                default: rf_waddr = rt;
            endcase
        end
    end

    // Datapath latches: IR on fetch, operands in DECODE, result and PC in EXEC, load data in MEM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= '0;
            ir      <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            alu_out <= '0;
            mdr     <= '0;
        end else begin
            if ((state == FETCH) && imem_ready) begin
                ir <= imem_rdata;
            end
            if (state == DECODE) begin
                a_reg <= rf_rdata_a;
                b_reg <= rf_rdata_b;
            end
            if (state == EXEC) begin
                alu_out <= alu_result;
                pc      <= pc_next;
            end
            if ((state == MEM) && dmem_ready) begin
                mdr <= dmem_rdata;
            end
        end
    end

    // Register file storage; writes to R0 are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (rf_we && (rf_waddr != 3'd0)) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

    assign imem_addr  = pc;
    assign pc_out     = pc;
    assign dmem_addr  = alu_out;
    assign dmem_wdata = b_reg;

endmodule
